ahb_slave_mux: RTL and testbench

- Response-side counterpart of the system address decoder on the AHB-Lite bus.
- Registers the address-phase slave selects into the data phase and steers the selected slave's HRDATA/HREADYOUT/HRESP back to the master.
- Contains the built-in default slave for slot 7, which covers unmapped addresses.
- Captures the address and a saturating count of unmapped accesses for debug.

---
 rtl/ahb_slave_mux.sv | 123 ++++++++++++
 tb/tb_ahb_slave_mux.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mux.sv
// ahb_slave_mux: AHB-Lite response mux with registered data-phase select,
// built-in default (unmapped) slave and unmapped-access debug capture.
`default_nettype none

module ahb_slave_mux #(
  parameter int DW    = 32,
  parameter int AW    = 36,
  parameter int NSLV  = 7,
  parameter int CNT_W = 8
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [NSLV:0]      HSEL,
  input  logic [AW-1:0]      HADDR,
  input  logic [1:0]         HTRANS,
  input  logic [NSLV*DW-1:0] HRDATA_S,
  input  logic [NSLV-1:0]    HREADYOUT_S,
  input  logic [NSLV-1:0]    HRESP_S,
  output logic [DW-1:0]      HRDATA,
  output logic               HREADY,
  output logic               HRESP,
  output logic [AW-1:0]      DEF_ERR_ADDR,
  output logic [CNT_W-1:0]   DEF_ERR_CNT
);

  typedef enum logic [1:0] {
    DS_OK   = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  ds_state_t       ds_state;
  ds_state_t       ds_next;
  logic [NSLV:0]   sel_enc;
  logic [NSLV:0]   sel_q;
  logic            ds_ready;
  logic            ds_resp;
  logic            take_err;
  logic            err_entry;
  logic [DW-1:0]   rdata_mux;
  logic            ready_mux;
  logic            resp_mux;

  // Lowest set index wins because decoder regions may overlap.
  always_comb begin
    sel_enc       = '0;
    sel_enc[NSLV] = 1'b1;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (HSEL[i]) begin
        sel_enc    = '0;
        sel_enc[i] = 1'b1;
      end
    end
  end

  always_comb begin
    ds_ready = 1'b1;
    ds_resp  = 1'b0;
    case (ds_state)
      DS_ERR1: begin
        ds_ready = 1'b0;
        ds_resp  = 1'b1;
      end
      DS_ERR2: ds_resp = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rdata_mux = '0;
    ready_mux = 1'b0;
    resp_mux  = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) begin
        rdata_mux = HRDATA_S[i*DW +: DW];
        ready_mux = HREADYOUT_S[i];
        resp_mux  = HRESP_S[i];
      end
    end
    if (sel_q[NSLV]) begin
      ready_mux = ds_ready;
      resp_mux  = ds_resp;
    end
  end

  assign HRDATA = rdata_mux;
  assign HREADY = ready_mux;
  assign HRESP  = resp_mux;

  assign take_err = HREADY & sel_enc[NSLV] & HTRANS[1];

  always_comb begin
    ds_next = ds_state;
    case (ds_state)
      DS_OK:   if (take_err) ds_next = DS_ERR1;
      DS_ERR1: ds_next = DS_ERR2;
      DS_ERR2: ds_next = take_err ? DS_ERR1 : DS_OK;
      default: ds_next = DS_OK;
    endcase
  end

  assign err_entry = (ds_state != DS_ERR1) && (ds_next == DS_ERR1);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ds_state     <= DS_OK;
      sel_q        <= '0;
      sel_q[NSLV]  <= 1'b1;
      DEF_ERR_ADDR <= '0;
      DEF_ERR_CNT  <= '0;
    end else begin
      ds_state <= ds_next;
      if (HREADY) sel_q <= sel_enc;
      if (err_entry) begin
        DEF_ERR_ADDR <= HADDR;
        if (DEF_ERR_CNT != '1) DEF_ERR_CNT <= DEF_ERR_CNT + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave_mux.sv
// tb_ahb_slave_mux: scoreboard bench; stimulus pushes expected responses,
// a negedge monitor pops and compares them against the DUT outputs.
`default_nettype none

module tb_ahb_slave_mux;
  localparam int DW    = 32;
  localparam int AW    = 36;
  localparam int NSLV  = 7;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic               HCLK = 1'b0;
  logic               HRESET;
  logic [NSLV:0]      HSEL;
  logic [AW-1:0]      HADDR;
  logic [1:0]         HTRANS;
  logic [NSLV*DW-1:0] HRDATA_S;
  logic [NSLV-1:0]    HREADYOUT_S;
  logic [NSLV-1:0]    HRESP_S;
  logic [DW-1:0]      HRDATA;
  logic               HREADY;
  logic               HRESP;
  logic [AW-1:0]      DEF_ERR_ADDR;
  logic [CNT_W-1:0]   DEF_ERR_CNT;

  ahb_slave_mux #(.DW(DW), .AW(AW), .NSLV(NSLV), .CNT_W(CNT_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .DEF_ERR_ADDR(DEF_ERR_ADDR), .DEF_ERR_CNT(DEF_ERR_CNT)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [DW-1:0]    data;
    logic             rdy;
    logic             resp;
    logic [AW-1:0]    addr;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: who owns the data phase, and which cycle of the
  // two-cycle ERROR response (0 = none, 1 = first, 2 = second) is shown.
  int            m_slot = NSLV;
  int            m_err  = 0;
  logic [AW-1:0] m_addr = '0;
  int            m_cnt  = 0;

  function automatic int pick(input logic [NSLV:0] s);
    for (int i = 0; i < NSLV; i++) if (s[i]) return i;
    return NSLV;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("hrdata", 64'(HRDATA), 64'(e.data));
      check("hready", 64'(HREADY), 64'(e.rdy));
      check("hresp",  64'(HRESP),  64'(e.resp));
      check("err_addr", 64'(DEF_ERR_ADDR), 64'(e.addr));
      check("err_cnt",  64'(DEF_ERR_CNT),  64'(e.cnt));
    end
  end

  task automatic cycle(input logic [NSLV:0] s, input logic [1:0] t, input logic [AW-1:0] a,
                       input logic [NSLV-1:0] rdy, input logic rst);
    exp_t e;
    HSEL        = s;
    HTRANS      = t;
    HADDR       = a;
    HREADYOUT_S = rdy;
    HRESP_S     = NSLV'($urandom);
    for (int i = 0; i < NSLV; i++) HRDATA_S[i*DW +: DW] = $urandom;
    HRESET      = rst;
    if (m_slot < NSLV) begin
      e.data = HRDATA_S[m_slot*DW +: DW];
      e.rdy  = rdy[m_slot];
      e.resp = HRESP_S[m_slot];
    end else begin
      e.data = '0;
      e.rdy  = (m_err != 1);
      e.resp = (m_err != 0);
    end
    e.addr = m_addr;
    e.cnt  = CNT_W'(m_cnt);
    exp_q.push_back(e);
    @(posedge HCLK);
    if (rst) begin
      m_slot = NSLV; m_err = 0; m_addr = '0; m_cnt = 0;
    end else begin
      if (m_err == 1) m_err = 2;
      else if (e.rdy && pick(s) == NSLV && t[1]) begin
        m_err  = 1;
        m_addr = a;
        if (m_cnt < CMAX) m_cnt++;
      end else m_err = 0;
      if (e.rdy) m_slot = pick(s);
    end
    #1;
  endtask

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [NSLV-1:0] ALL = '1;

  initial begin
    logic [NSLV-1:0] r;
    HRESET = 1'b1; HSEL = '0; HADDR = '0; HTRANS = IDLE;
    HRDATA_S = '0; HREADYOUT_S = '1; HRESP_S = '0;
    repeat (2) @(posedge HCLK);
    #1;
    cycle('0, IDLE, '0, ALL, 1'b0);

    // slot 0 single read
    cycle(8'h01, NONSEQ, 36'h0_0000_0100, ALL, 1'b0);
    cycle('0, IDLE, '0, ALL, 1'b0);

    // overlapping 1/2 with slot 1 stalling; new HSEL offered during stall
    cycle(8'h06, NONSEQ, 36'h0_1000_0000, ALL, 1'b0);
    repeat (3) cycle(8'h01, NONSEQ, 36'h0_0000_0200, ALL & ~7'h02, 1'b0);
    cycle('0, IDLE, '0, ALL, 1'b0);
    cycle('0, IDLE, '0, ALL, 1'b0);

    // reset during a slot-2 wait state
    cycle(8'h04, NONSEQ, 36'h0_2000_0000, ALL, 1'b0);
    cycle(8'h80, NONSEQ, 36'h0_2000_0004, ALL & ~7'h04, 1'b0);
    repeat (2) cycle(8'h80, NONSEQ, 36'h0_2000_0004, ALL & ~7'h04, 1'b1);
    cycle('0, IDLE, '0, ALL & ~7'h04, 1'b0);

    // unmapped access
    cycle(8'h80, NONSEQ, 36'h1_2345_0000, ALL, 1'b0);
    repeat (3) cycle('0, IDLE, '0, ALL, 1'b0);

    // back-to-back errors, then default-slot IDLE
    cycle(8'h80, NONSEQ, 36'h0_AAAA_0000, ALL, 1'b0);
    cycle('0, IDLE, '0, ALL, 1'b0);
    cycle(8'h80, SEQ, 36'h0_BBBB_0000, ALL, 1'b0);
    repeat (3) cycle('0, IDLE, '0, ALL, 1'b0);
    repeat (2) cycle(8'h80, IDLE, 36'h0_CCCC_0000, ALL, 1'b0);

    // counter saturation: ~300 captures
    for (int i = 0; i < 600; i++)
      cycle('0, NONSEQ, {4'h0, 32'($urandom)}, ALL, 1'b0);
    repeat (2) cycle('0, IDLE, '0, ALL, 1'b0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [NSLV:0] s;
      s = ($urandom_range(3) == 0) ? '0 : (NSLV+1)'($urandom);
      for (int k = 0; k < NSLV; k++) r[k] = ($urandom_range(3) != 0);
      cycle(s, 2'($urandom), {4'($urandom), 32'($urandom)}, r,
            ($urandom_range(199) == 0));
    end

    @(negedge HCLK);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
